seg7_scan_driver: RTL and testbench

// - Downstream consumer of the 16-bit nibble shift register: shows its 4 hex nibbles on a 4-digit multiplexed 7-segment display.
// - Time-multiplexes the digits with a refresh prescaler and drives active-low segment and anode lines.
// - Latches the input word once per scan frame, so a word changing mid-frame never shows mixed digits.

---
 rtl/seg7_scan_driver.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Shows a 16-bit word as four hex digits on a 4-digit multiplexed,
// common-anode 7-segment display. One digit is lit at a time. Each digit
// stays lit for REFRESH_DIV clocks.
//
// The input word and the decimal points are captured into a shadow register
// once per scan frame. Because of this, a word that changes in the middle of
// a frame never shows a mix of old and new digits.
//
// Parameters
//   REFRESH_DIV  number of clk cycles each digit stays lit (>= 2)
//   CNT_W        prescaler width, derived from REFRESH_DIV (do not override)
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   enable   in   1 = scan and display; 0 = blank all digits and freeze scan
//   data_in  in   [15:12] digit3 (leftmost) .. [3:0] digit0 (rightmost)
//   dp_in    in   decimal point per digit, 1 = lit
//   seg      out  active-low segments, seg[0]=a .. seg[6]=g
//   dp       out  active-low decimal point
//   an       out  active-low anodes, an[i] drives digit i
//
// Optional feature
//   LEADING_ZERO_BLANK_EN  When this is defined, a leading-zero digit i
//                          (i = 3..1) is blanked when nibbles i..3 are all
//                          zero and its decimal point is off. Digit 0 is
//                          always shown. A blanked digit keeps its full
//                          slot length.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

  // Hex to 7-segment decode. Bit order is gfedcba; a 0 bit lights a segment.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] presc_r;
  logic [1:0]       idx_r;
  logic [15:0]      shadow_data_r;
  logic [3:0]       shadow_dp_r;
  logic             loaded_r;     // 0 until the first enabled cycle after reset
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;

  logic             tick_s;
  logic             frame_end_s;
  logic [3:0]       nibble_s;
  logic             dp_bit_s;
  logic             blank_s;

  // Slot and frame boundaries. While enable is low, nothing advances.
  always_comb begin
    tick_s      = 1'b0;
    frame_end_s = 1'b0;
    if (enable && (presc_r == PRESC_MAX)) begin
      tick_s      = 1'b1;
      frame_end_s = (idx_r == 2'd3);
    end else begin
      tick_s      = 1'b0;
      frame_end_s = 1'b0;
    end
  end

  // Select the shadow nibble and decimal point for the current digit slot.
  always_comb begin
    nibble_s = 4'h0;
    dp_bit_s = 1'b0;
    case (idx_r)
      2'd0:    begin nibble_s = shadow_data_r[3:0];   dp_bit_s = shadow_dp_r[0]; end
      2'd1:    begin nibble_s = shadow_data_r[7:4];   dp_bit_s = shadow_dp_r[1]; end
      2'd2:    begin nibble_s = shadow_data_r[11:8];  dp_bit_s = shadow_dp_r[2]; end
      2'd3:    begin nibble_s = shadow_data_r[15:12]; dp_bit_s = shadow_dp_r[3]; end
      default: begin nibble_s = 4'h0;                 dp_bit_s = 1'b0;           end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero suppression. Blank a digit only when it and every digit to
  // its left are zero and its decimal point is off. Digit 0 is always shown.
  always_comb begin
    blank_s = 1'b0;
    case (idx_r)
      2'd3:    blank_s = (shadow_data_r[15:12] == 4'h0)  && !shadow_dp_r[3];
      2'd2:    blank_s = (shadow_data_r[15:8]  == 8'h00) && !shadow_dp_r[2];
      2'd1:    blank_s = (shadow_data_r[15:4]  == 12'h000) && !shadow_dp_r[1];
      default: blank_s = 1'b0;
    endcase
  end
`else
  // All digits are always shown, including leading zeros.
  always_comb begin
    blank_s = 1'b0;
  end
`endif

  // Prescaler, digit index and the per-frame shadow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r       <= {CNT_W{1'b0}};
      idx_r         <= 2'd0;
      shadow_data_r <= 16'h0000;
      shadow_dp_r   <= 4'h0;
      loaded_r      <= 1'b0;
    end else if (enable) begin
      if (tick_s) begin
        presc_r <= {CNT_W{1'b0}};
        idx_r   <= idx_r + 2'd1;
      end else begin
        presc_r <= presc_r + CNT_W'(1);
      end
      // Capture on the first enabled cycle after reset, then at each frame end.
      if (frame_end_s || !loaded_r) begin
        shadow_data_r <= data_in;
        shadow_dp_r   <= dp_in;
      end
      loaded_r <= 1'b1;
    end
  end

  // Registered pin drivers. There is one cycle of latency from an idx or
  // shadow change to the pins. The anode and segment lines switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= 4'hF;
    end else if (enable && !blank_s) begin
      seg_r <= hex_decode(nibble_s);
      dp_r  <= ~dp_bit_s;
      an_r  <= ~(4'b0001 << idx_r);
    end else begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= 4'hF;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with REFRESH_DIV = 4. Every expected
// pin value is computed by hand from the decode table and the scan timing.
//
// Timing used throughout: after the first enabled edge that follows reset,
// each digit slot covers four consecutive clock edges, in the order
// an = E, D, B, 7. Pins are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp;
  int n_err;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .data_in (data_in),
    .dp_in   (dp_in),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"},  {4'h0, an},   {4'h0, e_an});
    chk({tag, ".seg"}, {1'b0, seg},  {1'b0, e_seg});
    chk({tag, ".dp"},  {7'h00, dp},  {7'h00, e_dp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full digit slot: four edges, with the pins checked after each one.
  task automatic expect_slot(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_pins(tag, e_an, e_seg, e_dp);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    enable  = 1'b1;
    data_in = 16'h1234;
    dp_in   = 4'h0;

    // Reset hold: every output is at its idle value.
    step();
    step();
    chk_pins("reset", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;

    // Frame 0. Edge 1 loads the shadow, so the pins still show the
    // reset shadow (0) in slot 0; only the anode is checked on that edge.
    step();
    chk("first_an", {4'h0, an}, 8'h0E);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_pins("f0_d0", 4'hE, 7'h19, 1'b1);
    end
    expect_slot("f0_d1", 4'hD, 7'h30, 1'b1);
    expect_slot("f0_d2", 4'hB, 7'h24, 1'b1);
    expect_slot("f0_d3", 4'h7, 7'h79, 1'b1);

    // The new word waits for the frame boundary.
    data_in = 16'hABCD;
    expect_slot("f1_d0", 4'hE, 7'h19, 1'b1);
    expect_slot("f1_d1", 4'hD, 7'h30, 1'b1);
    expect_slot("f1_d2", 4'hB, 7'h24, 1'b1);
    expect_slot("f1_d3", 4'h7, 7'h79, 1'b1);
    expect_slot("abcd_d0", 4'hE, 7'h21, 1'b1);
    // The input drops to zero at idx=1; the rest of the frame keeps ABCD.
    data_in = 16'h0000;
    expect_slot("abcd_d1", 4'hD, 7'h46, 1'b1);
    expect_slot("abcd_d2", 4'hB, 7'h03, 1'b1);
    expect_slot("abcd_d3", 4'h7, 7'h08, 1'b1);
    expect_slot("zero_d0", 4'hE, 7'h40, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    expect_slot("zero_d1", 4'hF, 7'h7F, 1'b1);
    expect_slot("zero_d2", 4'hF, 7'h7F, 1'b1);
    expect_slot("zero_d3", 4'hF, 7'h7F, 1'b1);
`else
    expect_slot("zero_d1", 4'hD, 7'h40, 1'b1);
    expect_slot("zero_d2", 4'hB, 7'h40, 1'b1);
    expect_slot("zero_d3", 4'h7, 7'h40, 1'b1);
`endif

    // Decimal point only on digit 2. The capture happens at the end of the
    // next frame, so one frame is skipped before checking.
    data_in = 16'h8888;
    dp_in   = 4'b0100;
    repeat (16) step();
    expect_slot("dp_d0", 4'hE, 7'h00, 1'b1);
    expect_slot("dp_d1", 4'hD, 7'h00, 1'b1);
    expect_slot("dp_d2", 4'hB, 7'h00, 1'b0);
    expect_slot("dp_d3", 4'h7, 7'h00, 1'b1);

    // Disable in the middle of digit 2: two edges shown, then a 10-clk pause.
    expect_slot("pre_d0", 4'hE, 7'h00, 1'b1);
    expect_slot("pre_d1", 4'hD, 7'h00, 1'b1);
    step();
    chk_pins("pre_d2a", 4'hB, 7'h00, 1'b0);
    step();
    chk_pins("pre_d2b", 4'hB, 7'h00, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_pins("disabled", 4'hF, 7'h7F, 1'b1);
    end
    enable = 1'b1;
    // Digit 2 finishes its two remaining counts, then digit 3 follows.
    step();
    chk_pins("resume_d2a", 4'hB, 7'h00, 1'b0);
    step();
    chk_pins("resume_d2b", 4'hB, 7'h00, 1'b0);
    expect_slot("resume_d3", 4'h7, 7'h00, 1'b1);

    // Reset pulse while digit 3 is lit clears the pins at once.
    expect_slot("rs_d0", 4'hE, 7'h00, 1'b1);
    expect_slot("rs_d1", 4'hD, 7'h00, 1'b1);
    expect_slot("rs_d2", 4'hB, 7'h00, 1'b0);
    step();
    chk_pins("rs_d3", 4'h7, 7'h00, 1'b1);
    rst     = 1'b1;
    data_in = 16'h1234;
    dp_in   = 4'h0;
    #1;
    chk_pins("async_rst", 4'hF, 7'h7F, 1'b1);
    step();
    step();
    chk_pins("rst_hold", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    step();
    chk("restart_an", {4'h0, an}, 8'h0E);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_pins("restart_d0", 4'hE, 7'h19, 1'b1);
    end
    // The next word is captured at the end of this frame.
    data_in = 16'h0050;
    expect_slot("restart_d1", 4'hD, 7'h30, 1'b1);
    expect_slot("restart_d2", 4'hB, 7'h24, 1'b1);
    expect_slot("restart_d3", 4'h7, 7'h79, 1'b1);

    // 0x0050: leading zeros are blanked or shown, depending on the build.
    expect_slot("lz_d0", 4'hE, 7'h40, 1'b1);
    expect_slot("lz_d1", 4'hD, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    expect_slot("lz_d2", 4'hF, 7'h7F, 1'b1);
    expect_slot("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
    expect_slot("lz_d2", 4'hB, 7'h40, 1'b1);
    expect_slot("lz_d3", 4'h7, 7'h40, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
